// File: rtl/present_ctrl.sv
// PRESENT-80 iterative encryption controller: one round per cycle, valid/ready job handshake.
// Optional `PRESENT_ABORT_EN adds an abort input that cancels a job in RUN or FINAL.
module present_ctrl #(
   parameter int unsigned ROUNDS = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] pt,
   input  logic [79:0] key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] ct,
   output logic        busy
`ifdef PRESENT_ABORT_EN
   ,
   input  logic        abort
`endif
);

   typedef enum logic [1:0] {StIdle, StRun, StFinal, StDone} state_e;

   localparam logic [4:0] LastRc = 5'(ROUNDS);

   state_e      r_fsm;
   logic [63:0] r_state;
   logic [79:0] r_rkey;
   logic [4:0]  r_rc;
   logic [63:0] r_ct;
   logic        r_out_valid;

   logic [63:0] w_round;
   logic [79:0] w_key_rot;
   logic [79:0] w_next_key;
   logic        w_abort;

   function automatic logic [3:0] sbox4(input logic [3:0] d);
      logic [3:0] o;
      case (d)
         4'h0: o = 4'hC;
         4'h1: o = 4'h5;
         4'h2: o = 4'h6;
         4'h3: o = 4'hB;
         4'h4: o = 4'h9;
         4'h5: o = 4'h0;
         4'h6: o = 4'hA;
         4'h7: o = 4'hD;
         4'h8: o = 4'h3;
         4'h9: o = 4'hE;
         4'hA: o = 4'hF;
         4'hB: o = 4'h8;
         4'hC: o = 4'h4;
         4'hD: o = 4'h7;
         4'hE: o = 4'h1;
         default: o = 4'h2;
      endcase
      return o;
   endfunction

   function automatic logic [63:0] sbox_layer(input logic [63:0] d);
      logic [63:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[4*i +: 4] = sbox4(d[4*i +: 4]);
      end
      return o;
   endfunction

   // Bit i moves to position 16*i mod 63; bit 63 stays put.
   function automatic logic [63:0] p_layer(input logic [63:0] d);
      logic [63:0] o;
      o = '0;
      for (int i = 0; i < 63; i++) begin
         o[(i * 16) % 63] = d[i];
      end
      o[63] = d[63];
      return o;
   endfunction

`ifdef PRESENT_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   always_comb begin
      w_round    = p_layer(sbox_layer(r_state ^ r_rkey[79:16]));
      w_key_rot  = {r_rkey[18:0], r_rkey[79:19]};
      w_next_key = {sbox4(w_key_rot[79:76]), w_key_rot[75:20],
                    w_key_rot[19:15] ^ r_rc, w_key_rot[14:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm       <= StIdle;
         r_state     <= '0;
         r_rkey      <= '0;
         r_rc        <= '0;
         r_ct        <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_fsm)
            StIdle: begin
               if (in_valid) begin
                  r_state <= pt;
                  r_rkey  <= key;
                  r_rc    <= 5'd1;
                  r_fsm   <= StRun;
               end
            end
            StRun: begin
               if (w_abort) begin
                  r_fsm <= StIdle;
               end else begin
                  r_state <= w_round;
                  r_rkey  <= w_next_key;
                  if (r_rc == LastRc) begin
                     r_fsm <= StFinal;
                  end else begin
                     r_rc <= r_rc + 5'd1;
                  end
               end
            end
            StFinal: begin
               if (w_abort) begin
                  r_fsm <= StIdle;
               end else begin
                  r_ct        <= r_state ^ r_rkey[79:16];
                  r_out_valid <= 1'b1;
                  r_fsm       <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_fsm       <= StIdle;
               end
            end
            default: r_fsm <= StIdle;
         endcase
      end
   end

   assign in_ready  = (r_fsm == StIdle);
   assign busy      = (r_fsm != StIdle);
   assign out_valid = r_out_valid;
   assign ct        = r_ct;

endmodule

// File: doc/present_ctrl.md
PRESENT_CTRL -- requirements
Module: present_ctrl

Interface
REQ-001 The block SHALL have a single clock `clk`; reset `rst` is synchronous and active-high.
REQ-002 The block SHALL have parameter ROUNDS, default 31: number of round iterations; legal range 1..31.
REQ-003 Port `clk`, input, 1 bit: rising-edge clock for all state.
REQ-004 Port `rst`, input, 1 bit: synchronous active-high reset.
REQ-005 Port `in_valid`, input, 1 bit: pt/key presented.
REQ-006 Port `in_ready`, output, 1 bit: block can accept a job.
REQ-007 Port `pt`, input, 64 bits: plaintext block.
REQ-008 Port `key`, input, 80 bits: PRESENT-80 key.
REQ-009 Port `out_valid`, output, 1 bit: ct is valid.
REQ-010 Port `out_ready`, input, 1 bit: consumer takes ct.
REQ-011 Port `ct`, output, 64 bits: ciphertext.
REQ-012 Port `busy`, output, 1 bit: high in every state except IDLE.
REQ-013 Port `abort`, input, 1 bit: present only when PRESENT_ABORT_EN is defined.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, FINAL and DONE, encoded in 2 bits.
REQ-015 The block SHALL hold a 64-bit state register, an 80-bit round-key register and a 5-bit round counter `rc`.
REQ-016 `in_ready` SHALL equal (state==IDLE), combinationally.
REQ-017 Accept: on an IDLE edge with in_valid=1, the block SHALL capture state<=pt, rkey<=key, rc<=1 and go to RUN; pt and key are sampled only on this edge.
REQ-018 Each RUN edge SHALL perform state <= round(state, rkey) using the existing round datapath: key addition with rkey[79:16], sbox layer, pLayer.
REQ-019 On the same RUN edge, the key schedule SHALL apply three steps to produce the new rkey:
- rotate rkey left by 61;
- substitute bits [79:76] through the PRESENT sbox;
- XOR bits [19:15] with rc.
REQ-020 In RUN, if rc==ROUNDS the FSM SHALL go to FINAL; otherwise rc SHALL increment by 1 (no wrap, since rc never exceeds 31).
REQ-021 The FINAL edge SHALL perform ct <= state ^ rkey[79:16], set out_valid<=1 and go to DONE.
REQ-022 With ROUNDS=31, out_valid SHALL rise exactly 32 edges after the accepting edge; a new job can be accepted at the earliest 34 edges after the previous accept.
REQ-023 In DONE, ct and out_valid SHALL hold stable until out_ready=1.
REQ-024 On a DONE edge with out_ready=1, the block SHALL clear out_valid and go to IDLE.
REQ-025 A job SHALL NOT be accepted on the same edge as the DONE handshake; in_ready rises in the following cycle.
REQ-026 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-027 ct SHALL retain its last value after the DONE handshake until the next FINAL edge.

Reset
REQ-028 When rst=1 on an edge, the block SHALL set state=IDLE, out_valid=0, ct=0, rc=0, state register=0 and rkey=0; rst takes priority over every other input.
REQ-029 Reset during RUN, FINAL or DONE SHALL discard the job with no output.
REQ-030 in_ready SHALL be 1 and busy SHALL be 0 in the cycle after reset.

Configuration
REQ-031 When PRESENT_ABORT_EN is defined, the `abort` port SHALL exist, and abort=1 on an edge in RUN or FINAL SHALL return the FSM to IDLE with out_valid=0 and ct unchanged.
REQ-032 When PRESENT_ABORT_EN is defined, abort SHALL be ignored in IDLE and DONE.
REQ-033 When PRESENT_ABORT_EN is defined, rst SHALL have priority over abort.
REQ-034 When PRESENT_ABORT_EN is undefined, the `abort` port SHALL be absent and jobs SHALL always complete.

Verification
REQ-035 pt=0, key=0, out_ready=1 -> ct=5579C1387B228445, with out_valid rising 32 edges after accept.
REQ-036 pt=0, key=FFFFFFFFFFFFFFFFFFFF -> ct=E72C46C0F5945049; pt=FFFFFFFFFFFFFFFF, key=0 -> ct=A112FFC72F68417B.
REQ-037 pt and key all ones; out_ready held 0 for 10 cycles -> ct=3333DCD3213210D2 held stable, in_ready=0 throughout; out_ready=1 -> IDLE on the next cycle.
REQ-038 Change pt and key while in RUN, with in_valid=1 held -> the result is unaffected and no second job is accepted until after the DONE handshake.
REQ-039 Assert rst at rc=15 -> out_valid=0, ct=0 and in_ready=1 next cycle; a subsequent job with pt=0, key=0 gives 5579C1387B228445.
REQ-040 With PRESENT_ABORT_EN defined, abort at rc=20 -> IDLE and no out_valid; abort in DONE -> ignored and ct delivered.
